// File: rtl/bp_pkg.sv
// Shared definitions for the ARM branch predictor.
// Contents:
//   bp_mode_t   - PHT indexing mode (bimodal or gshare)
//   sat_inc     - saturating increment for a counter of a given width
//   sat_dec     - saturating decrement to zero
//   ctr_weak_nt - weakly-not-taken encoding for a counter of a given width
//   CTR_WEAK_NT - weakly-not-taken value for the default 2-bit counter
package bp_pkg;

   typedef enum logic [0:0] {
      BP_BIMODAL = 1'b0,
      BP_GSHARE  = 1'b1
   } bp_mode_t;

   localparam logic [1:0] CTR_WEAK_NT = 2'b01;

   // Counters are passed zero-extended to 32 bits; the caller truncates the result.
   function automatic logic [31:0] ctr_max(input int unsigned width);
      logic [31:0] v_max;
      if (width >= 32) v_max = '1;
      else             v_max = (32'd1 << width) - 32'd1;
      return v_max;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
      logic [31:0] v_res;
      if (value >= ctr_max(width)) v_res = ctr_max(width);
      else                         v_res = value + 32'd1;
      return v_res;
   endfunction

   function automatic logic [31:0] sat_dec(input logic [31:0] value, input int unsigned width);
      logic [31:0] v_res;
      if (value == 32'd0) v_res = 32'd0;
      else                v_res = value - 32'd1;
      return v_res;
   endfunction

   function automatic logic [31:0] ctr_weak_nt(input int unsigned width);
      return (32'd1 << (width - 1)) - 32'd1;
   endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: array of saturating counters.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   i_rd_idx      - combinational read index
//   o_rd_ctr      - counter value at i_rd_idx (registered state, no bypass)
//   i_wr_en       - apply a training update this edge
//   i_wr_idx      - counter to train
//   i_wr_taken    - 1: saturating increment, 0: saturating decrement
//   i_clr         - synchronous clear of all counters to weakly-not-taken (beats i_wr_en)
module bp_pht
   import bp_pkg::*;
#(
   parameter int unsigned ENTRIES  = 64,
   parameter int unsigned CTR_BITS = 2,
   localparam int unsigned IDX     = $clog2(ENTRIES)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [IDX-1:0]      i_rd_idx,
   output logic [CTR_BITS-1:0] o_rd_ctr,
   input  logic                i_wr_en,
   input  logic [IDX-1:0]      i_wr_idx,
   input  logic                i_wr_taken,
   input  logic                i_clr
);

   localparam logic [CTR_BITS-1:0] WEAK_NT = CTR_BITS'(ctr_weak_nt(CTR_BITS));

   logic [CTR_BITS-1:0] r_ctr [ENTRIES];
   logic [CTR_BITS-1:0] w_ctr_next;

   always_comb begin
      o_rd_ctr = r_ctr[i_rd_idx];
   end

   always_comb begin
      w_ctr_next = r_ctr[i_wr_idx];
      if (i_wr_taken) w_ctr_next = CTR_BITS'(sat_inc(32'(r_ctr[i_wr_idx]), CTR_BITS));
      else            w_ctr_next = CTR_BITS'(sat_dec(32'(r_ctr[i_wr_idx]), CTR_BITS));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(ENTRIES); i++) r_ctr[i] <= WEAK_NT;
      end else if (i_clr) begin
         for (int i = 0; i < int'(ENTRIES); i++) r_ctr[i] <= WEAK_NT;
      end else if (i_wr_en) begin
         r_ctr[i_wr_idx] <= w_ctr_next;
      end
   end

endmodule

// File: rtl/arm_branch_predictor.sv
// Dynamic branch predictor for the 5-stage ARM pipeline: direct-mapped BTB plus a PHT of
// saturating counters, bimodal (MODE 0) or gshare (MODE 1) indexed.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   lookup_pc                  - fetch PC; pred_hit/pred_taken/pred_target answer it combinationally
//   upd_valid, upd_pc,
//   upd_taken, upd_target      - branch resolved in Execute (training)
//   upd_pred_taken,
//   upd_pred_target            - prediction that travelled with the branch
//   upd_mispredict             - combinational mispredict flag for the resolving branch
//   inv_all                    - synchronous invalidate of BTB, PHT and history
//   stat_branches,
//   stat_mispredicts           - saturating event counters, cleared only by reset
module arm_branch_predictor
   import bp_pkg::*;
#(
   parameter int unsigned ENTRIES   = 64,
   parameter int unsigned CTR_BITS  = 2,
   parameter int unsigned HIST_BITS = 6,
   parameter int unsigned MODE      = 0,
   parameter int unsigned PC_WIDTH  = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [PC_WIDTH-1:0] lookup_pc,
   output logic                pred_hit,
   output logic                pred_taken,
   output logic [PC_WIDTH-1:0] pred_target,
   input  logic                upd_valid,
   input  logic [PC_WIDTH-1:0] upd_pc,
   input  logic                upd_taken,
   input  logic [PC_WIDTH-1:0] upd_target,
   input  logic                upd_pred_taken,
   input  logic [PC_WIDTH-1:0] upd_pred_target,
   output logic                upd_mispredict,
   input  logic                inv_all,
   output logic [31:0]         stat_branches,
   output logic [31:0]         stat_mispredicts
);

   localparam int unsigned IDX   = $clog2(ENTRIES);
   localparam int unsigned TAG_W = PC_WIDTH - IDX - 2;
   localparam bit GSHARE         = (MODE == int'(BP_GSHARE));

   // BTB storage; only the valid bits need reset
   logic [ENTRIES-1:0]  r_btb_valid;
   logic [TAG_W-1:0]    r_btb_tag [ENTRIES];
   logic [PC_WIDTH-1:0] r_btb_tgt [ENTRIES];
   logic [HIST_BITS-1:0] r_ghr;
   logic [31:0]          r_stat_br;
   logic [31:0]          r_stat_mp;

   logic [IDX-1:0]       w_lk_bi;
   logic [TAG_W-1:0]     w_lk_tag;
   logic [IDX-1:0]       w_up_bi;
   logic [TAG_W-1:0]     w_up_tag;
   logic [IDX-1:0]       w_ghr_ext;
   logic [IDX-1:0]       w_lk_pht_idx;
   logic [IDX-1:0]       w_up_pht_idx;
   logic [CTR_BITS-1:0]  w_lk_ctr;
   logic                 w_hit;
   logic                 w_train;
   logic [HIST_BITS-1:0] w_ghr_shift;
   logic                 w_unused_pc_lsbs;

   assign w_lk_bi  = lookup_pc[IDX+1:2];
   assign w_lk_tag = lookup_pc[PC_WIDTH-1:IDX+2];
   assign w_up_bi  = upd_pc[IDX+1:2];
   assign w_up_tag = upd_pc[PC_WIDTH-1:IDX+2];
   assign w_unused_pc_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

   assign w_ghr_ext    = GSHARE ? IDX'(r_ghr) : '0;
   assign w_lk_pht_idx = w_lk_bi ^ w_ghr_ext;
   assign w_up_pht_idx = w_up_bi ^ w_ghr_ext;

   // inv_all wins over a same-cycle training write
   assign w_train = upd_valid & ~inv_all;

   generate
      if (HIST_BITS == 1) begin : g_hist1
         assign w_ghr_shift = upd_taken;
      end else begin : g_histn
         assign w_ghr_shift = {r_ghr[HIST_BITS-2:0], upd_taken};
      end
   endgenerate

   bp_pht #(
      .ENTRIES  (ENTRIES),
      .CTR_BITS (CTR_BITS)
   ) u_pht (
      .clk        (clk),
      .reset      (reset),
      .i_rd_idx   (w_lk_pht_idx),
      .o_rd_ctr   (w_lk_ctr),
      .i_wr_en    (w_train),
      .i_wr_idx   (w_up_pht_idx),
      .i_wr_taken (upd_taken),
      .i_clr      (inv_all)
   );

   // Lookup: no bypass from a same-cycle update
   always_comb begin
      w_hit       = r_btb_valid[w_lk_bi] && (r_btb_tag[w_lk_bi] == w_lk_tag);
      pred_hit    = w_hit;
      pred_taken  = w_hit & w_lk_ctr[CTR_BITS-1];
      pred_target = w_hit ? r_btb_tgt[w_lk_bi] : '0;
   end

   always_comb begin
      upd_mispredict = upd_valid &
                       ((upd_taken != upd_pred_taken) |
                        (upd_taken & upd_pred_taken & (upd_target != upd_pred_target)));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_btb_valid <= '0;
      end else if (inv_all) begin
         r_btb_valid <= '0;
      end else if (w_train && upd_taken) begin
         r_btb_valid[w_up_bi] <= 1'b1;
      end
   end

   // Allocate on taken only; an alias at the same index is simply overwritten
   always_ff @(posedge clk) begin
      if (w_train && upd_taken) begin
         r_btb_tag[w_up_bi] <= w_up_tag;
         r_btb_tgt[w_up_bi] <= upd_target;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ghr <= '0;
      end else if (inv_all) begin
         r_ghr <= '0;
      end else if (w_train && GSHARE) begin
         r_ghr <= w_ghr_shift;
      end
   end

   // Stats count every resolved branch, including one dropped by inv_all
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stat_br <= '0;
         r_stat_mp <= '0;
      end else begin
         if (upd_valid && (r_stat_br != 32'hFFFF_FFFF))      r_stat_br <= r_stat_br + 32'd1;
         if (upd_mispredict && (r_stat_mp != 32'hFFFF_FFFF)) r_stat_mp <= r_stat_mp + 32'd1;
      end
   end

   assign stat_branches    = r_stat_br;
   assign stat_mispredicts = r_stat_mp;

endmodule

// File: tb/tb_arm_branch_predictor.sv
// Self-checking bench for arm_branch_predictor: a bimodal instance driven from a vector
// table, plus hand sequences for inv_all, gshare history and asynchronous reset.
module tb_arm_branch_predictor;

   logic        clk;
   logic        reset;

   // bimodal instance signals
   logic [31:0] lookup_pc, upd_pc, upd_target, upd_pred_target, pred_target;
   logic        upd_valid, upd_taken, upd_pred_taken, inv_all;
   logic        pred_hit, pred_taken, upd_mispredict;
   logic [31:0] stat_branches, stat_mispredicts;

   // gshare instance signals
   logic [31:0] g_lookup_pc, g_upd_pc, g_upd_target, g_upd_pred_target, g_pred_target;
   logic        g_upd_valid, g_upd_taken, g_upd_pred_taken, g_inv_all;
   logic        g_pred_hit, g_pred_taken, g_upd_mispredict;
   logic [31:0] g_stat_branches, g_stat_mispredicts;

   int n_total;
   int n_pass;

   arm_branch_predictor #(
      .ENTRIES(64), .CTR_BITS(2), .HIST_BITS(6), .MODE(0), .PC_WIDTH(32)
   ) u_bi (
      .clk              (clk),
      .reset            (reset),
      .lookup_pc        (lookup_pc),
      .pred_hit         (pred_hit),
      .pred_taken       (pred_taken),
      .pred_target      (pred_target),
      .upd_valid        (upd_valid),
      .upd_pc           (upd_pc),
      .upd_taken        (upd_taken),
      .upd_target       (upd_target),
      .upd_pred_taken   (upd_pred_taken),
      .upd_pred_target  (upd_pred_target),
      .upd_mispredict   (upd_mispredict),
      .inv_all          (inv_all),
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
   );

   arm_branch_predictor #(
      .ENTRIES(64), .CTR_BITS(2), .HIST_BITS(6), .MODE(1), .PC_WIDTH(32)
   ) u_gs (
      .clk              (clk),
      .reset            (reset),
      .lookup_pc        (g_lookup_pc),
      .pred_hit         (g_pred_hit),
      .pred_taken       (g_pred_taken),
      .pred_target      (g_pred_target),
      .upd_valid        (g_upd_valid),
      .upd_pc           (g_upd_pc),
      .upd_taken        (g_upd_taken),
      .upd_target       (g_upd_target),
      .upd_pred_taken   (g_upd_pred_taken),
      .upd_pred_target  (g_upd_pred_target),
      .upd_mispredict   (g_upd_mispredict),
      .inv_all          (g_inv_all),
      .stat_branches    (g_stat_branches),
      .stat_mispredicts (g_stat_mispredicts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] lpc;
      logic        uv;
      logic [31:0] upc;
      logic        ut;
      logic [31:0] utgt;
      logic        upt;
      logic [31:0] uptgt;
      logic        eh;
      logic        et;
      logic [31:0] etgt;
      logic        em;
   } vec_t;

   vec_t vecs[21];

   function automatic vec_t mk(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                               input logic ut, input logic [31:0] utgt, input logic upt,
                               input logic [31:0] uptgt, input logic eh, input logic et,
                               input logic [31:0] etgt, input logic em);
      vec_t v;
      v.lpc = lpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.upt = upt;
      v.uptgt = uptgt; v.eh = eh; v.et = et; v.etgt = etgt; v.em = em;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic bi_drive(input logic uv, input logic [31:0] upc, input logic ut,
                           input logic [31:0] utgt, input logic upt, input logic [31:0] uptgt);
      upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
      upd_pred_taken = upt; upd_pred_target = uptgt;
   endtask

   task automatic gs_drive(input logic uv, input logic [31:0] upc, input logic ut,
                           input logic [31:0] utgt);
      g_upd_valid = uv; g_upd_pc = upc; g_upd_taken = ut; g_upd_target = utgt;
      g_upd_pred_taken = 1'b0; g_upd_pred_target = '0;
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      reset = 1'b1;
      lookup_pc = '0; inv_all = 1'b0;
      bi_drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
      g_lookup_pc = '0; g_inv_all = 1'b0;
      gs_drive(1'b0, '0, 1'b0, '0);

      //           lpc        uv upc        ut utgt       upt uptgt      eh et etgt       em
      vecs[0]  = mk(32'h100,  0, 32'h0,     0, 32'h0,     0, 32'h0,     0, 0, 32'h0,   0);
      vecs[1]  = mk(32'h100,  1, 32'h100,   1, 32'h200,   0, 32'h0,     0, 0, 32'h0,   1);
      vecs[2]  = mk(32'h100,  0, 32'h0,     0, 32'h0,     0, 32'h0,     1, 1, 32'h200, 0);
      vecs[3]  = mk(32'h1100, 0, 32'h0,     0, 32'h0,     0, 32'h0,     0, 0, 32'h0,   0);
      vecs[4]  = mk(32'h100,  1, 32'h100,   1, 32'h200,   1, 32'h200,   1, 1, 32'h200, 0);
      vecs[5]  = mk(32'h100,  1, 32'h100,   1, 32'h200,   1, 32'h200,   1, 1, 32'h200, 0);
      vecs[6]  = mk(32'h100,  1, 32'h100,   0, 32'h0,     1, 32'h200,   1, 1, 32'h200, 1);
      vecs[7]  = mk(32'h100,  1, 32'h100,   0, 32'h0,     1, 32'h200,   1, 1, 32'h200, 1);
      vecs[8]  = mk(32'h100,  1, 32'h100,   0, 32'h0,     0, 32'h0,     1, 0, 32'h200, 0);
      vecs[9]  = mk(32'h100,  1, 32'h100,   0, 32'h0,     0, 32'h0,     1, 0, 32'h200, 0);
      vecs[10] = mk(32'h100,  0, 32'h0,     0, 32'h0,     0, 32'h0,     1, 0, 32'h200, 0);
      vecs[11] = mk(32'h100,  1, 32'h100,   1, 32'h200,   0, 32'h0,     1, 0, 32'h200, 1);
      vecs[12] = mk(32'h100,  0, 32'h0,     0, 32'h0,     0, 32'h0,     1, 0, 32'h200, 0);
      vecs[13] = mk(32'h100,  1, 32'h100,   1, 32'h204,   1, 32'h200,   1, 0, 32'h200, 1);
      vecs[14] = mk(32'h100,  0, 32'h0,     0, 32'h0,     0, 32'h0,     1, 1, 32'h204, 0);
      vecs[15] = mk(32'h1100, 1, 32'h1100,  1, 32'h300,   1, 32'h300,   0, 0, 32'h0,   0);
      vecs[16] = mk(32'h100,  0, 32'h0,     0, 32'h0,     0, 32'h0,     0, 0, 32'h0,   0);
      vecs[17] = mk(32'h1100, 0, 32'h0,     0, 32'h0,     0, 32'h0,     1, 1, 32'h300, 0);
      vecs[18] = mk(32'h104,  1, 32'h104,   0, 32'h0,     0, 32'h0,     0, 0, 32'h0,   0);
      vecs[19] = mk(32'h104,  0, 32'h0,     0, 32'h0,     0, 32'h0,     0, 0, 32'h0,   0);
      vecs[20] = mk(32'h100,  0, 32'h100,   1, 32'h0,     0, 32'h0,     0, 0, 32'h0,   0);

      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset_stat_branches", stat_branches, 32'd0);
      chk("reset_stat_mispredicts", stat_mispredicts, 32'd0);

      // Outputs sampled 1 ns after the negedge, i.e. before this vector's update edge
      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         lookup_pc = vecs[i].lpc;
         bi_drive(vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utgt, vecs[i].upt, vecs[i].uptgt);
         #1;
         chk($sformatf("v%0d_hit", i), 32'(pred_hit), 32'(vecs[i].eh));
         chk($sformatf("v%0d_taken", i), 32'(pred_taken), 32'(vecs[i].et));
         chk($sformatf("v%0d_target", i), pred_target, vecs[i].etgt);
         chk($sformatf("v%0d_mispredict", i), 32'(upd_mispredict), 32'(vecs[i].em));
      end

      @(negedge clk);
      bi_drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
      #1;
      chk("table_stat_branches", stat_branches, 32'd11);
      chk("table_stat_mispredicts", stat_mispredicts, 32'd5);

      // inv_all together with a taken update: the update must not allocate
      @(negedge clk);
      inv_all = 1'b1;
      bi_drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
      @(negedge clk);
      inv_all = 1'b0;
      bi_drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
      lookup_pc = 32'h100;
      #1;
      chk("inv_hit_100", 32'(pred_hit), 32'd0);
      lookup_pc = 32'h1100;
      #1;
      chk("inv_hit_1100", 32'(pred_hit), 32'd0);
      chk("inv_stat_branches", stat_branches, 32'd12);
      chk("inv_stat_mispredicts", stat_mispredicts, 32'd5);

      // Counter cleared to 01: taken then not-taken lands on 01 -> predict not taken
      @(negedge clk);
      bi_drive(1'b1, 32'h1100, 1'b1, 32'h300, 1'b1, 32'h300);
      @(negedge clk);
      bi_drive(1'b1, 32'h1100, 1'b0, 32'h0, 1'b1, 32'h300);
      @(negedge clk);
      bi_drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
      #1;
      chk("inv_ctr_hit", 32'(pred_hit), 32'd1);
      chk("inv_ctr_taken", 32'(pred_taken), 32'd0);
      chk("inv_ctr_target", pred_target, 32'h300);
      chk("post_inv_stat_branches", stat_branches, 32'd14);
      chk("post_inv_stat_mispredicts", stat_mispredicts, 32'd6);

      // gshare: two taken at 0x40 train indices 16 and 17, GHR=000011, lookup hits index 19
      @(negedge clk);
      gs_drive(1'b1, 32'h40, 1'b1, 32'h80);
      @(negedge clk);
      gs_drive(1'b1, 32'h40, 1'b1, 32'h80);
      @(negedge clk);
      gs_drive(1'b0, '0, 1'b0, '0);
      g_lookup_pc = 32'h40;
      #1;
      chk("gs_hit", 32'(g_pred_hit), 32'd1);
      chk("gs_taken", 32'(g_pred_taken), 32'd0);
      chk("gs_target", g_pred_target, 32'h80);

      // inv_all must clear GHR; with GHR=0 the two updates train indices 19 and 17,
      // leaving GHR=3 so lookup 0x40 reads index 19 (10) and 0x4C reads index 16 (01)
      @(negedge clk);
      g_inv_all = 1'b1;
      gs_drive(1'b1, 32'h40, 1'b1, 32'h80);
      @(negedge clk);
      g_inv_all = 1'b0;
      gs_drive(1'b1, 32'h4C, 1'b1, 32'h90);
      @(negedge clk);
      gs_drive(1'b1, 32'h40, 1'b1, 32'h80);
      @(negedge clk);
      gs_drive(1'b0, '0, 1'b0, '0);
      g_lookup_pc = 32'h40;
      #1;
      chk("gs_inv_hit_40", 32'(g_pred_hit), 32'd1);
      chk("gs_inv_taken_40", 32'(g_pred_taken), 32'd1);
      g_lookup_pc = 32'h4C;
      #1;
      chk("gs_inv_hit_4c", 32'(g_pred_hit), 32'd1);
      chk("gs_inv_taken_4c", 32'(g_pred_taken), 32'd0);
      chk("gs_inv_target_4c", g_pred_target, 32'h90);
      chk("gs_stat_branches", g_stat_branches, 32'd5);

      // Asynchronous reset between edges
      @(negedge clk);
      lookup_pc = 32'h1100;
      #2;
      reset = 1'b1;
      #1;
      chk("areset_stat_branches", stat_branches, 32'd0);
      chk("areset_stat_mispredicts", stat_mispredicts, 32'd0);
      chk("areset_hit", 32'(pred_hit), 32'd0);
      chk("areset_gs_stat_branches", g_stat_branches, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/arm_branch_predictor.md
Name: arm_branch_predictor

Overview:
Parametrised dynamic branch predictor for the 5-stage ARM pipeline. It combines a direct-mapped branch target buffer (BTB) with a pattern history table (PHT) of saturating counters, and is selectable between bimodal and gshare indexing. Fetch queries it combinationally with PCF to redirect early on predicted-taken branches. Execute reports resolved branches (BranchE and outcome) for training and mispredict detection, which removes the fixed flush-on-every-taken-branch penalty.

Parameters:
ENTRIES, 64, number of BTB and PHT entries; power of two, >= 4; IDX = log2(ENTRIES).
CTR_BITS, 2, width of each PHT saturating counter; >= 1.
HIST_BITS, 6, global history length; 1..IDX.
MODE, 0, 0 = bimodal, 1 = gshare.
PC_WIDTH, 32, PC and target width.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
lookup_pc  in  PC_WIDTH  fetch PC (PCF)
pred_hit  out  1  BTB valid and tag match for lookup_pc
pred_taken  out  1  predict taken (hit and counter MSB set)
pred_target  out  PC_WIDTH  stored target on hit, else 0
upd_valid  in  1  a branch resolved in Execute this cycle
upd_pc  in  PC_WIDTH  PC of the resolved branch
upd_taken  in  1  actual outcome
upd_target  in  PC_WIDTH  actual target
upd_pred_taken  in  1  prediction carried down the pipe with the branch
upd_pred_target  in  PC_WIDTH  predicted target carried down the pipe
upd_mispredict  out  1  combinational mispredict flag
inv_all  in  1  synchronous invalidate of all predictor state
stat_branches  out  32  resolved-branch count
stat_mispredicts  out  32  mispredict count

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- On reset: all BTB valid bits = 0; every counter = weakly-not-taken (2^(CTR_BITS-1)-1, which is 01 for 2 bits); GHR = 0; both stat counters = 0.
- Outputs after reset: pred_hit = 0, pred_taken = 0, pred_target = 0, upd_mispredict = 0 while upd_valid = 0.
- BTB index bi = pc[IDX+1:2]; tag = pc[PC_WIDTH-1:IDX+2].
- PHT index: MODE 0 uses bi. MODE 1 uses bi XOR zero-extended GHR.
- Lookup is purely combinational from registered state, so it has 0-cycle latency. There is no bypass: a lookup and an update in the same cycle see the pre-update state.
- Update on a clk edge with upd_valid = 1 and inv_all = 0:
  - PHT index is computed from upd_pc and the current GHR.
  - Taken: counter increments, saturating at 2^CTR_BITS-1. The BTB entry is written with valid = 1, tag, and upd_target, overwriting any alias.
  - Not taken: counter decrements, saturating at 0. The BTB entry is untouched; no allocation on not-taken.
  - MODE 1: GHR <= {GHR[HIST_BITS-2:0], upd_taken}. MODE 0: GHR stays 0.
- upd_mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & (upd_target != upd_pred_target))).
- Stats are updated every edge and independently of inv_all:
  - stat_branches += upd_valid.
  - stat_mispredicts += upd_mispredict.
  - Both saturate at 32'hFFFFFFFF. Only reset clears them.
- inv_all on an edge: clears all valid bits, resets counters to weakly-not-taken, and clears GHR. It takes priority over a simultaneous upd_valid table/GHR write; stats still count that update.
- Reset asserted mid-operation clears all state immediately, with no clock needed.
- Aliasing (same index, different tag): lookup reports a miss. PHT aliasing is tolerated and unprotected.

Decomposition:
- Shared package bp_pkg:
  - enum bp_mode_t {BP_BIMODAL, BP_GSHARE}.
  - Functions sat_inc and sat_dec, parametrised on width.
  - Constant CTR_WEAK_NT.
- One sub-module, bp_pht: counter array with a combinational read port, a saturating update port, and a clear-all.
- BTB arrays, GHR, and stats stay in the top module.

Test Plan:
1. Reset, then lookup_pc = 0x100 -> pred_hit = 0, pred_taken = 0, pred_target = 0; stats = 0.
2. Bimodal. One update: pc 0x100, taken, target 0x200. Next cycle lookup 0x100 -> hit 1, taken 1, target 0x200. Lookup 0x1100 (same index 0, different tag) -> hit 0.
3. Saturation. Three taken updates on 0x100 (counter 11), then one not-taken -> taken still 1 (counter 10). Three more not-taken -> counter 00 and stays 00; hit 1, taken 0.
4. MODE = 1, HIST_BITS = 6. Taken at 0x40 twice: first write trains PHT index 16, second trains 17, and GHR = 000011. Lookup 0x40 -> PHT index 19 (weak NT), so hit 1, taken 0.
5. Mispredict checks:
   - upd_valid, taken 1, pred_taken 0 -> upd_mispredict 1 in the same cycle; stat_mispredicts = 1 after the edge.
   - taken 1, pred_taken 1, target 0x204 vs predicted 0x200 -> mispredict 1.
   - taken 0, pred_taken 0 -> mispredict 0; stat_branches increments.
6. inv_all with simultaneous upd_valid (pc 0x100 taken) -> next cycle lookup 0x100 hit 0, GHR 0, stat_branches incremented. Then assert reset between edges -> stats read 0 immediately.
